// File: rtl/xfer_burst_splitter.sv
// Splits a byte-length command into bursts that never exceed MAX_BURST_BYTES
// and never cross a BOUNDARY_BYTES address boundary. Each burst descriptor is
// handed off over a four-phase req/ack handshake.
module xfer_burst_splitter #(
  parameter int C_SLV_ADDRESS_WIDTH = 64,
  parameter int C_SLV_BURST_LENGTH  = 13,
  parameter int CMD_LEN_WIDTH       = 32,
  parameter int MAX_BURST_BYTES     = 4096,
  parameter int BOUNDARY_BYTES      = 4096,
  parameter int XFER_PARAMS_WIDTH   = C_SLV_ADDRESS_WIDTH + C_SLV_BURST_LENGTH + 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [C_SLV_ADDRESS_WIDTH-1:0] cmd_addr_i,
  input  logic [CMD_LEN_WIDTH-1:0]       cmd_len_i,
  input  logic                           cmd_rnw_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  output logic [XFER_PARAMS_WIDTH-1:0]   xfer_params_o,
  output logic                           xfer_params_req_o,
  input  logic                           xfer_params_ack_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [15:0]                    burst_count_o
);

  localparam int A  = C_SLV_ADDRESS_WIDTH;
  localparam int L  = C_SLV_BURST_LENGTH;
  // Wide enough for remaining length, MAX_BURST_BYTES and BOUNDARY_BYTES.
  localparam int CW = (CMD_LEN_WIDTH > 32) ? CMD_LEN_WIDTH + 1 : 33;

  typedef enum logic [1:0] {IDLE, CALC, REQ, DROP} state_e;

  state_e                   state_q, state_d;
  logic                     rdy_q;
  logic [A-1:0]             addr_q;
  logic [CMD_LEN_WIDTH-1:0] rem_q;
  logic                     rnw_q;
  logic [15:0]              cnt_q;
  logic                     done_q;
  logic [XFER_PARAMS_WIDTH-1:0] desc_q;
  logic [L-1:0]             chunk_q;
  logic [CW-1:0]            off_w, room_w, chunk_w;
  logic                     accept;

  assign chunk_q           = desc_q[A+L-1:A];
  assign cmd_ready_o       = (state_q == IDLE) && rdy_q;
  assign accept            = cmd_valid_i && cmd_ready_o;
  assign busy_o            = (state_q != IDLE);
  assign xfer_params_req_o = (state_q == REQ);
  assign xfer_params_o     = desc_q;
  assign done_o            = done_q;
  assign burst_count_o     = cnt_q;

  // Burst size: min(remaining, max burst, bytes left before the boundary).
  always_comb begin
    off_w   = CW'(addr_q) & CW'(BOUNDARY_BYTES - 1);
    room_w  = CW'(BOUNDARY_BYTES) - off_w;
    chunk_w = CW'(rem_q);
    if (CW'(MAX_BURST_BYTES) < chunk_w) chunk_w = CW'(MAX_BURST_BYTES);
    if (room_w < chunk_w)               chunk_w = room_w;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; req is only reissued after ack has been seen low.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && (cmd_len_i != '0)) state_d = CALC;
      CALC: state_d = REQ;
      REQ:  if (xfer_params_ack_i) state_d = DROP;
      DROP: if (!xfer_params_ack_i) state_d = (rem_q != '0) ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command bookkeeping, descriptor register and completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_q  <= 1'b0;
      addr_q <= '0;
      rem_q  <= '0;
      rnw_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      desc_q <= '0;
    end else begin
      rdy_q  <= 1'b1;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          addr_q <= cmd_addr_i;
          rem_q  <= cmd_len_i;
          rnw_q  <= cmd_rnw_i;
          cnt_q  <= '0;
          if (cmd_len_i == '0) done_q <= 1'b1;
        end
        CALC: desc_q <= {1'b1, rnw_q, L'(chunk_w), addr_q};
        REQ: if (xfer_params_ack_i) begin
          addr_q <= addr_q + A'(chunk_q);
          rem_q  <= rem_q - CMD_LEN_WIDTH'(chunk_q);
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
        DROP: if (!xfer_params_ack_i && (rem_q == '0)) done_q <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xfer_burst_splitter.sv
// Directed bench for xfer_burst_splitter: inputs driven and outputs sampled
// on the falling clock edge.
module tb_xfer_burst_splitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] cmd_addr = '0;
  logic [31:0] cmd_len = '0;
  logic        cmd_rnw = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [78:0] params;
  logic        req;
  logic        ack = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] bcnt;

  int checks = 0;
  int errors = 0;

  xfer_burst_splitter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len), .cmd_rnw_i(cmd_rnw),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .xfer_params_o(params), .xfer_params_req_o(req), .xfer_params_ack_i(ack),
    .busy_o(busy), .done_o(done), .burst_count_o(bcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a falling edge; returns at the falling edge after acceptance.
  task automatic send_cmd(input logic [63:0] a, input logic [31:0] l, input logic r);
    chk("cmd_ready_idle", 96'(cmd_ready), 96'd1);
    cmd_addr = a; cmd_len = l; cmd_rnw = r; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Count falling edges until req is seen high, bounded.
  task automatic wait_req(output int n);
    n = 0;
    while (!req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req) chk("req_timeout", 96'(req), 96'd1);
  endtask

  // Expect one burst, ack it, hold ack for 'hold' cycles.
  task automatic burst(input logic [63:0] ea, input int el, input logic er,
                       input int hold, input int ecnt, output int lat);
    wait_req(lat);
    chk("params", 96'(params), 96'({1'b1, er, 13'(el), ea}));
    chk("busy_req", 96'(busy), 96'd1);
    chk("ready_req", 96'(cmd_ready), 96'd0);
    ack = 1'b1;
    @(negedge clk);
    chk("req_drop", 96'(req), 96'd0);
    chk("burst_count", 96'(bcnt), 96'(ecnt));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("req_low_ack_high", 96'(req), 96'd0);
    end
    ack = 1'b0;
  endtask

  task automatic expect_done(input int ecnt);
    @(negedge clk);
    chk("done_pulse", 96'(done), 96'd1);
    chk("busy_done", 96'(busy), 96'd0);
    chk("count_final", 96'(bcnt), 96'(ecnt));
    @(negedge clk);
    chk("done_one_cycle", 96'(done), 96'd0);
    chk("count_hold", 96'(bcnt), 96'(ecnt));
  endtask

  initial begin
    int lat;
    // Reset state
    #2;
    chk("rst_req", 96'(req), 96'd0);
    chk("rst_ready", 96'(cmd_ready), 96'd0);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_done", 96'(done), 96'd0);
    chk("rst_count", 96'(bcnt), 96'd0);
    chk("rst_params", 96'(params), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 96'(cmd_ready), 96'd1);

    // Stray ack in IDLE is ignored
    ack = 1'b1;
    @(negedge clk);
    chk("idle_ack_req", 96'(req), 96'd0);
    chk("idle_ack_busy", 96'(busy), 96'd0);
    ack = 1'b0;
    @(negedge clk);

    // 8 KiB write from 0: two 4 KiB bursts; ack held 5 cycles on the first
    send_cmd(64'h0, 32'd8192, 1'b0);
    chk("busy_calc", 96'(busy), 96'd1);
    burst(64'h0, 4096, 1'b0, 5, 1, lat);
    chk("first_req_latency", 96'(lat), 96'd1);
    burst(64'h1000, 4096, 1'b0, 1, 2, lat);
    chk("req_after_ack_fall", 96'(lat), 96'd2);
    expect_done(2);

    // Read crossing the 4 KiB boundary
    send_cmd(64'hF00, 32'd512, 1'b1);
    chk("count_cleared", 96'(bcnt), 96'd0);
    burst(64'hF00, 256, 1'b1, 1, 1, lat);
    burst(64'h1000, 256, 1'b1, 2, 2, lat);
    expect_done(2);

    // Unaligned start followed by a short tail
    send_cmd(64'h10, 32'd5000, 1'b0);
    burst(64'h10, 4080, 1'b0, 1, 1, lat);
    burst(64'h1000, 920, 1'b0, 1, 2, lat);
    expect_done(2);

    // Zero length: done next cycle, no request
    send_cmd(64'h1234, 32'd0, 1'b1);
    chk("zero_done", 96'(done), 96'd1);
    chk("zero_req", 96'(req), 96'd0);
    chk("zero_busy", 96'(busy), 96'd0);
    chk("zero_count", 96'(bcnt), 96'd0);
    @(negedge clk);
    chk("zero_done_clear", 96'(done), 96'd0);
    chk("zero_req2", 96'(req), 96'd0);

    // Address wrap at the top of the 64-bit space
    send_cmd(64'hFFFF_FFFF_FFFF_FF00, 32'd512, 1'b0);
    burst(64'hFFFF_FFFF_FFFF_FF00, 256, 1'b0, 1, 1, lat);
    burst(64'h0, 256, 1'b0, 1, 2, lat);
    expect_done(2);

    // Reset during REQ of the second burst
    send_cmd(64'h0, 32'd12288, 1'b0);
    burst(64'h0, 4096, 1'b0, 1, 1, lat);
    wait_req(lat);
    chk("pre_rst_req", 96'(req), 96'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 96'(req), 96'd0);
    chk("rst_mid_busy", 96'(busy), 96'd0);
    chk("rst_mid_done", 96'(done), 96'd0);
    chk("rst_mid_count", 96'(bcnt), 96'd0);
    chk("rst_mid_params", 96'(params), 96'd0);
    chk("rst_mid_ready", 96'(cmd_ready), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 96'(req), 96'd0);
    chk("post_rst_busy", 96'(busy), 96'd0);
    send_cmd(64'h2000, 32'd100, 1'b1);
    chk("post_rst_count", 96'(bcnt), 96'd0);
    burst(64'h2000, 100, 1'b1, 1, 1, lat);
    expect_done(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xfer_burst_splitter.md
XFER_BURST_SPLITTER -- requirements
Module: xfer_burst_splitter

Interface
REQ-001 The parameters SHALL be: C_SLV_ADDRESS_WIDTH, default 64, address field width; C_SLV_BURST_LENGTH, default 13, burst length field width in bytes; CMD_LEN_WIDTH, default 32, command length width in bytes; MAX_BURST_BYTES, default 4096, largest burst issued, must be below 2**C_SLV_BURST_LENGTH; BOUNDARY_BYTES, default 4096, power of two, address boundary no burst may cross; XFER_PARAMS_WIDTH, default C_SLV_ADDRESS_WIDTH+C_SLV_BURST_LENGTH+2, width of the packed descriptor.
REQ-002 The ports SHALL be as follows, one per line, in this order:
  clk_i  input  1  single clock, all logic on the rising edge
  rst_ni  input  1  reset, asynchronous, active-low
  cmd_addr_i  input  C_SLV_ADDRESS_WIDTH  start byte address
  cmd_len_i  input  CMD_LEN_WIDTH  total byte count
  cmd_rnw_i  input  1  1 = read, 0 = write
  cmd_valid_i  input  1  command valid
  cmd_ready_o  output  1  command accepted when valid and ready are both high
  xfer_params_o  output  XFER_PARAMS_WIDTH  packed burst descriptor
  xfer_params_req_o  output  1  four-phase request
  xfer_params_ack_i  input  1  four-phase acknowledge
  busy_o  output  1  a command is in progress
  done_o  output  1  one-cycle pulse when a command completes
  burst_count_o  output  16  bursts completed for the current or last command

Function
REQ-003 xfer_params_o SHALL be packed as: bit [A+L+1] = burst_start = 1; bit [A+L] = rnw; bits [A+L-1:A] = burst length in bytes; bits [A-1:0] = burst address (A = C_SLV_ADDRESS_WIDTH, L = C_SLV_BURST_LENGTH).
REQ-004 The state machine SHALL have the states IDLE, CALC, REQ and DROP.
REQ-005 IDLE: cmd_ready_o = 1. On cmd_valid_i, the block SHALL latch addr, len and rnw, clear burst_count_o and go to CALC. A zero length SHALL instead pulse done_o in the next cycle and stay in IDLE.
REQ-006 CALC (1 cycle): chunk = min(remaining, MAX_BURST_BYTES, BOUNDARY_BYTES - (addr mod BOUNDARY_BYTES)). The block SHALL register the descriptor and go to REQ.
REQ-007 REQ: xfer_params_req_o = 1 and xfer_params_o SHALL be held stable. When xfer_params_ack_i = 1, the block SHALL drop the request next cycle, go to DROP, and update addr += chunk, remaining -= chunk and burst_count_o += 1.
REQ-008 DROP: xfer_params_req_o = 0 until xfer_params_ack_i = 0. Then the block SHALL go to CALC if remaining > 0; otherwise it SHALL pulse done_o for one cycle and go to IDLE.
REQ-009 xfer_params_req_o SHALL NOT be reasserted while xfer_params_ack_i = 1. xfer_params_o SHALL NOT change while the request is high.
REQ-010 cmd_ready_o SHALL be 0 in every state except IDLE; busy_o SHALL be 1 in every state except IDLE.
REQ-011 The address SHALL wrap modulo 2**C_SLV_ADDRESS_WIDTH with no error flag. The remaining count SHALL never underflow (chunk <= remaining).
REQ-012 burst_count_o SHALL saturate at 16'hFFFF and hold its value after done_o until the next command is accepted.
REQ-013 An ack that arrives while in IDLE or CALC SHALL be ignored.

Reset
REQ-014 While rst_ni = 0, asynchronously: state = IDLE; xfer_params_req_o, done_o, busy_o, burst_count_o and xfer_params_o all 0; cmd_ready_o = 0 during reset and 1 from the first clock after release.
REQ-015 A reset during REQ or DROP SHALL drop xfer_params_req_o at once and discard the command. There SHALL be no retry after reset.

Verification
REQ-016 Command addr 0x0, len 8192, write -> 2 bursts: (0x0, 4096) then (0x1000, 4096), both with rnw = 0 and start = 1; burst_count_o = 2; one done_o pulse.
REQ-017 Command addr 0xF00, len 512, read -> bursts (0xF00, 256) then (0x1000, 256); rnw = 1.
REQ-018 Command with len 0 -> no request raised; done_o high exactly one cycle after acceptance.
REQ-019 Ack held high for 5 cycles after the first burst -> request stays low for all 5 cycles; the next request rises no earlier than 2 cycles after ack falls (DROP exit, then CALC).
REQ-020 rst_ni pulsed low while in REQ of the second burst -> xfer_params_req_o is 0 in the same cycle, all outputs read 0, and after release a new command is accepted with burst_count_o = 0.
REQ-021 Command addr 0xFFFF_FFFF_FFFF_FF00, len 512 -> bursts (…FF00, 256) then (0x0, 256), with no error.
